// File: rtl/m14k_dspram_resp.sv
// DSPRAM responder for the M14K DSP_* port: word array, base/enable config, wait-state FSM.
// Optional parity storage is enabled by defining M14K_DSPRAM_PARITY_EN.
module m14k_dspram_resp #(
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        gclk,
    input  logic        greset_n,
    input  logic [17:0] DSP_DataAddr,
    input  logic        DSP_DataRdStr,
    input  logic        DSP_DataWrStr,
    input  logic [3:0]  DSP_DataWrMask,
    input  logic [31:0] DSP_DataWrValue,
    input  logic [3:0]  DSP_WPar,
    input  logic        DSP_ParityEn,
    input  logic [23:0] DSP_TagCmpValue,
    input  logic [17:0] DSP_TagAddr,
    input  logic        DSP_TagRdStr,
    input  logic        DSP_TagWrStr,
    output logic [31:0] DSP_DataRdValue,
    output logic [3:0]  DSP_RPar,
    output logic [23:0] DSP_TagRdValue,
    output logic        DSP_Hit,
    output logic        DSP_Stall,
    output logic        DSP_Present,
    output logic        DSP_ParPresent
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t                 r_state, w_state_nxt;
    logic [1:0]             r_cnt, w_cnt_nxt;
    logic [ADDR_BITS-1:0]   r_idx, w_ld_idx;
    logic [3:0]             r_mask;
    logic [31:0]            r_wdata;
    logic                   r_wr;
    logic [19:0]            r_base;
    logic                   r_en;
    logic [31:0]            r_rdata;
    logic [23:0]            r_tag_rd, w_tag_sel;
    logic                   r_stall;
    logic [31:0]            r_mem [DEPTH];

    logic                   w_strobe, w_accept, w_ld_rd, w_hit, w_commit, w_bypass;
    logic [31:0]            w_pa, w_base_pa, w_merged, w_ld_data;
    logic                   w_unused;

    // Region check on the top PA bits above the array span
    assign w_pa      = {DSP_TagCmpValue[21:0], 10'b0};
    assign w_base_pa = {r_base, 12'b0};
    assign w_hit     = r_en && ((w_pa >> (ADDR_BITS + 2)) == (w_base_pa >> (ADDR_BITS + 2)));

    assign w_strobe  = DSP_DataRdStr || DSP_DataWrStr;
    assign w_commit  = (r_state == ST_RESP) && r_wr && w_hit && greset_n;
    assign w_bypass  = w_commit && (w_ld_idx == r_idx);

    always_comb begin
        w_merged = r_mem[r_idx];
        for (int b = 0; b < 4; b++) begin
            if (r_mask[b]) w_merged[8*b +: 8] = r_wdata[8*b +: 8];
        end
    end

    assign w_ld_data = w_bypass ? w_merged : r_mem[w_ld_idx];

    // Next-state: accept in IDLE/RESP, count down wait states
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_ld_rd     = 1'b0;
        w_ld_idx    = r_idx;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_strobe) begin
                    w_accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = ST_RESP;
                        w_ld_rd     = !DSP_DataWrStr;
                        w_ld_idx    = DSP_DataAddr[ADDR_BITS-1:0];
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = 2'(WAIT_STATES);
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 2'd1) begin
                    w_state_nxt = ST_RESP;
                    w_ld_rd     = !r_wr;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tag_sel = '0;
        case (DSP_TagAddr[3:2])
            2'd0:    w_tag_sel = {r_base, 3'b0, r_en};
            2'd1:    w_tag_sel = {15'b0, 5'(ADDR_BITS), 4'b0};
            default: w_tag_sel = '0;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (!greset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_wr     <= 1'b0;
            r_base   <= '0;
            r_en     <= 1'b0;
            r_rdata  <= '0;
            r_tag_rd <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stall <= (w_state_nxt == ST_WAIT);
            if (w_accept)     r_wr     <= DSP_DataWrStr;
            if (w_ld_rd)      r_rdata  <= w_ld_data;
            if (DSP_TagRdStr) r_tag_rd <= w_tag_sel;
            if (DSP_TagWrStr) begin
                r_base <= DSP_TagCmpValue[23:4];
                r_en   <= DSP_TagCmpValue[0];
            end
        end
    end

    // Request payload is only meaningful while an access is in flight
    always_ff @(posedge gclk) begin
        if (w_accept) begin
            r_idx   <= DSP_DataAddr[ADDR_BITS-1:0];
            r_mask  <= DSP_DataWrMask;
            r_wdata <= DSP_DataWrValue;
        end
    end

    always_ff @(posedge gclk) begin
        if (w_commit) r_mem[r_idx] <= w_merged;
    end

`ifdef M14K_DSPRAM_PARITY_EN
    logic [3:0] r_pmem [DEPTH];
    logic [3:0] r_wpar, r_rpar, w_pmerged;
    logic       r_par_en;

    always_comb begin
        w_pmerged = r_pmem[r_idx];
        for (int b = 0; b < 4; b++) begin
            if (r_mask[b]) w_pmerged[b] = r_par_en & r_wpar[b];
        end
    end

    always_ff @(posedge gclk) begin
        if (w_accept) begin
            r_wpar   <= DSP_WPar;
            r_par_en <= DSP_ParityEn;
        end
        if (w_commit) r_pmem[r_idx] <= w_pmerged;
    end

    always_ff @(posedge gclk) begin
        if (!greset_n)    r_rpar <= '0;
        else if (w_ld_rd) r_rpar <= w_bypass ? w_pmerged : r_pmem[w_ld_idx];
    end

    assign DSP_RPar       = r_rpar;
    assign DSP_ParPresent = 1'b1;
    assign w_unused       = ^{DSP_DataAddr[17:ADDR_BITS], DSP_TagAddr[17:4], DSP_TagAddr[1:0]};
`else
    assign DSP_RPar       = 4'b0;
    assign DSP_ParPresent = 1'b0;
    assign w_unused       = ^{DSP_DataAddr[17:ADDR_BITS], DSP_TagAddr[17:4], DSP_TagAddr[1:0],
                              DSP_WPar, DSP_ParityEn};
`endif

    assign DSP_DataRdValue = r_rdata;
    assign DSP_TagRdValue  = r_tag_rd;
    assign DSP_Hit         = (r_state == ST_RESP) && w_hit;
    assign DSP_Stall       = r_stall;
    assign DSP_Present     = 1'b1;

endmodule

// File: tb/tb_m14k_dspram_resp.sv
// Scoreboard bench for m14k_dspram_resp: zero-wait instance plus a two-wait-state instance on shared inputs.
module tb_m14k_dspram_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        greset_n;
    logic [17:0] data_addr;
    logic        rd_str, wr_str;
    logic [3:0]  wr_mask;
    logic [31:0] wr_value;
    logic [3:0]  wpar;
    logic        par_en;
    logic [23:0] tag_cmp;
    logic [17:0] tag_addr;
    logic        tag_rd, tag_wr;

    logic [31:0] rd0, rd2;
    logic [3:0]  rpar0, rpar2;
    logic [23:0] tagrd0, tagrd2;
    logic        hit0, hit2, stall0, stall2, pres0, pres2, ppres0, ppres2;

    m14k_dspram_resp #(.ADDR_BITS(10), .WAIT_STATES(0)) u_dut0 (
        .gclk(clk), .greset_n(greset_n), .DSP_DataAddr(data_addr), .DSP_DataRdStr(rd_str),
        .DSP_DataWrStr(wr_str), .DSP_DataWrMask(wr_mask), .DSP_DataWrValue(wr_value),
        .DSP_WPar(wpar), .DSP_ParityEn(par_en), .DSP_TagCmpValue(tag_cmp), .DSP_TagAddr(tag_addr),
        .DSP_TagRdStr(tag_rd), .DSP_TagWrStr(tag_wr), .DSP_DataRdValue(rd0), .DSP_RPar(rpar0),
        .DSP_TagRdValue(tagrd0), .DSP_Hit(hit0), .DSP_Stall(stall0), .DSP_Present(pres0),
        .DSP_ParPresent(ppres0)
    );

    m14k_dspram_resp #(.ADDR_BITS(10), .WAIT_STATES(2)) u_dut2 (
        .gclk(clk), .greset_n(greset_n), .DSP_DataAddr(data_addr), .DSP_DataRdStr(rd_str),
        .DSP_DataWrStr(wr_str), .DSP_DataWrMask(wr_mask), .DSP_DataWrValue(wr_value),
        .DSP_WPar(wpar), .DSP_ParityEn(par_en), .DSP_TagCmpValue(tag_cmp), .DSP_TagAddr(tag_addr),
        .DSP_TagRdStr(tag_rd), .DSP_TagWrStr(tag_wr), .DSP_DataRdValue(rd2), .DSP_RPar(rpar2),
        .DSP_TagRdValue(tagrd2), .DSP_Hit(hit2), .DSP_Stall(stall2), .DSP_Present(pres2),
        .DSP_ParPresent(ppres2)
    );

`ifdef M14K_DSPRAM_PARITY_EN
    localparam logic PAR_PRESENT = 1'b1;
`else
    localparam logic PAR_PRESENT = 1'b0;
`endif

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
        logic [3:0]  par;
    } exp_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] pa;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [3:0]  wp;
        logic        pe;
    } op_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [19:0] m_base;
    logic        m_en;
    logic [31:0] m_mem [1024];
    logic [3:0]  m_par [1024];
    logic [31:0] m_last_rd;
    logic [3:0]  m_last_par;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_str = 1'b0; wr_str = 1'b0; tag_rd = 1'b0; tag_wr = 1'b0;
    endtask

    function automatic logic m_hit(input logic [31:0] pa);
        return m_en && (pa[31:12] == m_base);
    endfunction

    // Drive one data strobe and push the response the model expects in its RESP cycle
    task automatic drive(input op_t op);
        exp_t       e;
        logic [9:0] idx;
        idx       = op.pa[11:2];
        data_addr = op.pa[19:2];
        tag_cmp   = {2'b0, op.pa[31:10]};
        rd_str    = op.rd;   wr_str = op.wr;  wr_mask = op.mask;
        wr_value  = op.data; wpar   = op.wp;  par_en  = op.pe;
        e.hit     = m_hit(op.pa);
        if (op.wr && e.hit) begin
            for (int b = 0; b < 4; b++) begin
                if (op.mask[b]) begin
                    m_mem[idx][8*b +: 8] = op.data[8*b +: 8];
                    m_par[idx][b]        = op.pe & op.wp[b];
                end
            end
        end
        if (op.rd && !op.wr) begin
            m_last_rd = m_mem[idx];
`ifdef M14K_DSPRAM_PARITY_EN
            m_last_par = m_par[idx];
`else
            m_last_par = 4'b0;
`endif
        end
        e.data = m_last_rd;
        e.par  = m_last_par;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        greset_n = 1'b0;
        data_addr = '0; wr_mask = '0; wr_value = '0; wpar = '0; par_en = 1'b0;
        tag_cmp = '0; tag_addr = '0;
        idle();
        m_base = '0; m_en = 1'b0; m_last_rd = '0; m_last_par = '0;
        repeat (3) tick();
        n_checks++; if (rd0 !== 32'h0)   begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rd0); end
        n_checks++; if (rpar0 !== 4'h0)  begin n_fail++; $display("FAIL reset_rpar: got %h expected 0", rpar0); end
        n_checks++; if (tagrd0 !== 24'h0) begin n_fail++; $display("FAIL reset_tagrd: got %h expected 0", tagrd0); end
        n_checks++; if (hit0 !== 1'b0)   begin n_fail++; $display("FAIL reset_hit: got %b expected 0", hit0); end
        n_checks++; if ({stall0, stall2} !== 2'b00) begin n_fail++; $display("FAIL reset_stall: got %b expected 00", {stall0, stall2}); end
        n_checks++; if ({pres0, pres2} !== 2'b11) begin n_fail++; $display("FAIL reset_present: got %b expected 11", {pres0, pres2}); end
        n_checks++; if ({ppres0, ppres2} !== {2{PAR_PRESENT}}) begin n_fail++; $display("FAIL reset_parpresent: got %b expected %b", {ppres0, ppres2}, {2{PAR_PRESENT}}); end
        greset_n = 1'b1;
        tick();
    endtask

    task automatic test_tag_config();
        tag_cmp = {20'h00080, 3'b0, 1'b1}; tag_wr = 1'b1;
        m_base = 20'h00080; m_en = 1'b1;
        tick();
        tag_wr = 1'b0; tag_rd = 1'b1; tag_addr = 18'h0;
        tick();
        n_checks++; if (tagrd0 !== 24'h000801) begin n_fail++; $display("FAIL tag_sel0: got %h expected 000801", tagrd0); end
        tag_addr = 18'h4;
        tick();
        n_checks++; if (tagrd0 !== 24'h0000A0) begin n_fail++; $display("FAIL tag_sel1: got %h expected 0000a0", tagrd0); end
        tag_addr = 18'h8;
        tick();
        n_checks++; if (tagrd0 !== 24'h0) begin n_fail++; $display("FAIL tag_sel2: got %h expected 0", tagrd0); end
        tag_addr = 18'h0;
        tick();
        tag_rd = 1'b0; tag_addr = 18'h4;
        tick();
        n_checks++; if (tagrd2 !== 24'h000801) begin n_fail++; $display("FAIL tag_hold: got %h expected 000801", tagrd2); end
    endtask

    task automatic test_write_merge();
        exp_t e;
        op_t  ops [3];
        ops[0] = '{rd:1'b0, wr:1'b1, pa:32'h0008_0010, mask:4'hF, data:32'hDEADBEEF, wp:4'h0, pe:1'b0};
        ops[1] = '{rd:1'b0, wr:1'b1, pa:32'h0008_0010, mask:4'h1, data:32'h000000AA, wp:4'h0, pe:1'b0};
        ops[2] = '{rd:1'b1, wr:1'b0, pa:32'h0008_0010, mask:4'h0, data:32'h0,        wp:4'h0, pe:1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(ops[i]);
            tick();
            e = sb_q.pop_front();
            n_checks++; if (hit0 !== e.hit)  begin n_fail++; $display("FAIL merge_hit[%0d]: got %b expected %b", i, hit0, e.hit); end
            n_checks++; if (rd0 !== e.data)  begin n_fail++; $display("FAIL merge_rdata[%0d]: got %h expected %h", i, rd0, e.data); end
            n_checks++; if (rpar0 !== e.par) begin n_fail++; $display("FAIL merge_rpar[%0d]: got %h expected %h", i, rpar0, e.par); end
        end
        n_checks++; if (rd0 !== 32'hDEADBEAA) begin n_fail++; $display("FAIL merge_value: got %h expected deadbeaa", rd0); end
        idle();
        tick();
        n_checks++; if (hit0 !== 1'b0) begin n_fail++; $display("FAIL merge_hit_idle: got %b expected 0", hit0); end
    endtask

    task automatic test_miss();
        exp_t e;
        op_t  ops [3];
        ops[0] = '{rd:1'b0, wr:1'b1, pa:32'h0010_0010, mask:4'hF, data:32'h12345678, wp:4'h0, pe:1'b0};
        ops[1] = '{rd:1'b1, wr:1'b0, pa:32'h0010_0010, mask:4'h0, data:32'h0,        wp:4'h0, pe:1'b0};
        ops[2] = '{rd:1'b1, wr:1'b0, pa:32'h0008_0010, mask:4'h0, data:32'h0,        wp:4'h0, pe:1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(ops[i]);
            tick();
            e = sb_q.pop_front();
            n_checks++; if (hit0 !== e.hit)  begin n_fail++; $display("FAIL miss_hit[%0d]: got %b expected %b", i, hit0, e.hit); end
            n_checks++; if (rd0 !== e.data)  begin n_fail++; $display("FAIL miss_rdata[%0d]: got %h expected %h", i, rd0, e.data); end
            n_checks++; if (rpar0 !== e.par) begin n_fail++; $display("FAIL miss_rpar[%0d]: got %h expected %h", i, rpar0, e.par); end
            idle();
            tick();
        end
        n_checks++; if (rd0 !== 32'hDEADBEAA) begin n_fail++; $display("FAIL miss_untouched: got %h expected deadbeaa", rd0); end
    endtask

    // Write/read pairs on index 5 with no gap, including a combined read+write strobe
    task automatic test_back_to_back();
        exp_t e;
        op_t  ops [6];
        ops[0] = '{rd:1'b0, wr:1'b1, pa:32'h0008_0014, mask:4'hF, data:32'hCAFEF00D, wp:4'h0, pe:1'b0};
        ops[1] = '{rd:1'b1, wr:1'b0, pa:32'h0008_0014, mask:4'h0, data:32'h0,        wp:4'h0, pe:1'b0};
        ops[2] = '{rd:1'b0, wr:1'b1, pa:32'h0008_0014, mask:4'h4, data:32'h00550000, wp:4'h0, pe:1'b0};
        ops[3] = '{rd:1'b1, wr:1'b0, pa:32'h0008_0014, mask:4'h0, data:32'h0,        wp:4'h0, pe:1'b0};
        ops[4] = '{rd:1'b1, wr:1'b1, pa:32'h0008_0014, mask:4'h1, data:32'h00000011, wp:4'h0, pe:1'b0};
        ops[5] = '{rd:1'b1, wr:1'b0, pa:32'h0008_0014, mask:4'h0, data:32'h0,        wp:4'h0, pe:1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(ops[i]);
            tick();
            e = sb_q.pop_front();
            n_checks++; if (hit0 !== e.hit)  begin n_fail++; $display("FAIL b2b_hit[%0d]: got %b expected %b", i, hit0, e.hit); end
            n_checks++; if (rd0 !== e.data)  begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", i, rd0, e.data); end
            n_checks++; if (rpar0 !== e.par) begin n_fail++; $display("FAIL b2b_rpar[%0d]: got %h expected %h", i, rpar0, e.par); end
        end
        n_checks++; if (rd0 !== 32'hCA55F011) begin n_fail++; $display("FAIL b2b_value: got %h expected ca55f011", rd0); end
        idle();
        tick();
    endtask

    task automatic test_parity();
        exp_t e;
        op_t  ops [4];
        ops[0] = '{rd:1'b0, wr:1'b1, pa:32'h0008_0018, mask:4'hF, data:32'h0BADCAFE, wp:4'hA, pe:1'b1};
        ops[1] = '{rd:1'b1, wr:1'b0, pa:32'h0008_0018, mask:4'h0, data:32'h0,        wp:4'h0, pe:1'b0};
        ops[2] = '{rd:1'b0, wr:1'b1, pa:32'h0008_0018, mask:4'h2, data:32'h00007700, wp:4'hF, pe:1'b0};
        ops[3] = '{rd:1'b1, wr:1'b0, pa:32'h0008_0018, mask:4'h0, data:32'h0,        wp:4'h0, pe:1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i]);
            tick();
            e = sb_q.pop_front();
            n_checks++; if (hit0 !== e.hit)  begin n_fail++; $display("FAIL par_hit[%0d]: got %b expected %b", i, hit0, e.hit); end
            n_checks++; if (rd0 !== e.data)  begin n_fail++; $display("FAIL par_rdata[%0d]: got %h expected %h", i, rd0, e.data); end
            n_checks++; if (rpar0 !== e.par) begin n_fail++; $display("FAIL par_rpar[%0d]: got %h expected %h", i, rpar0, e.par); end
        end
        idle();
        tick();
    endtask

    // Two-wait-state instance: stall window, ignored strobe, data in the third cycle
    task automatic test_wait_states();
        repeat (3) tick();
        data_addr = 18'h20008; tag_cmp = 24'h000200;
        wr_mask = 4'hF; wr_value = 32'h5A5A1234; wpar = 4'h0; par_en = 1'b0; wr_str = 1'b1;
        tick();
        wr_str = 1'b0;
        tick();
        tick();
        n_checks++; if ({hit2, stall2} !== 2'b10) begin n_fail++; $display("FAIL ws_write_resp: got hit,stall=%b expected 10", {hit2, stall2}); end
        tick();
        rd_str = 1'b1;
        tick();
        n_checks++; if ({hit2, stall2} !== 2'b01) begin n_fail++; $display("FAIL ws_stall1: got hit,stall=%b expected 01", {hit2, stall2}); end
        data_addr = 18'h20009;
        tick();
        n_checks++; if ({hit2, stall2} !== 2'b01) begin n_fail++; $display("FAIL ws_stall2: got hit,stall=%b expected 01", {hit2, stall2}); end
        rd_str = 1'b0;
        tick();
        n_checks++; if ({hit2, stall2} !== 2'b10) begin n_fail++; $display("FAIL ws_resp: got hit,stall=%b expected 10", {hit2, stall2}); end
        n_checks++; if (rd2 !== 32'h5A5A1234) begin n_fail++; $display("FAIL ws_rdata: got %h expected 5a5a1234", rd2); end
        tick();
        n_checks++; if ({hit2, stall2} !== 2'b00) begin n_fail++; $display("FAIL ws_ignored_strobe: got hit,stall=%b expected 00", {hit2, stall2}); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        data_addr = 18'h20008; tag_cmp = 24'h000200;
        wr_mask = 4'hF; wr_value = 32'hFFFF0000; wr_str = 1'b1;
        tick();
        wr_str = 1'b0;
        n_checks++; if (stall2 !== 1'b1) begin n_fail++; $display("FAIL rstw_stall_before: got %b expected 1", stall2); end
        greset_n = 1'b0;
        tick();
        n_checks++; if (stall2 !== 1'b0) begin n_fail++; $display("FAIL rstw_stall_after: got %b expected 0", stall2); end
        n_checks++; if (rd2 !== 32'h0) begin n_fail++; $display("FAIL rstw_rdata_reset: got %h expected 0", rd2); end
        n_checks++; if (tagrd2 !== 24'h0) begin n_fail++; $display("FAIL rstw_tagrd_reset: got %h expected 0", tagrd2); end
        greset_n = 1'b1;
        tick();
        tag_cmp = 24'h000801; tag_wr = 1'b1;
        tick();
        tag_wr = 1'b0; tag_cmp = 24'h000200; data_addr = 18'h20008; rd_str = 1'b1;
        tick();
        rd_str = 1'b0;
        tick();
        tick();
        n_checks++; if (hit2 !== 1'b1) begin n_fail++; $display("FAIL rstw_hit: got %b expected 1", hit2); end
        n_checks++; if (rd2 !== 32'h5A5A1234) begin n_fail++; $display("FAIL rstw_unchanged: got %h expected 5a5a1234", rd2); end
        tick();
    endtask

    initial begin
        test_reset();
        test_tag_config();
        test_write_merge();
        test_miss();
        test_back_to_back();
        test_parity();
        test_wait_states();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/m14k_dspram_resp.md
# m14k_dspram_resp

Data scratchpad RAM responder for the M14K core's DSPRAM port. It is the memory-side end of the `DSP_*` interface that the core's dcc SPRAM logic drives. The block holds a single-port word array with byte write masks and a programmable base-address register. It resolves hits against the physical address the core supplies and returns read data, hit and stall with a configurable number of wait states. It drops in wherever a configuration replaces the SPRAM stub with a real DSPRAM.

## Interface
Parameters:
- `ADDR_BITS`, 10: word-index width; region size is 2^(ADDR_BITS+2) bytes. Legal range 10..16.
- `WAIT_STATES`, 0: extra stall cycles per access. Legal range 0..3.

Ports:
- `gclk`  in  1  core clock, the only clock.
- `greset_n`  in  1  reset; **synchronous, active-low**.
- `DSP_DataAddr`  in  18  word address [19:2]; the low ADDR_BITS bits index the array.
- `DSP_DataRdStr`  in  1  read strobe, one cycle.
- `DSP_DataWrStr`  in  1  write strobe, one cycle.
- `DSP_DataWrMask`  in  4  byte enables.
- `DSP_DataWrValue`  in  32  write data.
- `DSP_WPar`  in  4  write parity bits.
- `DSP_ParityEn`  in  1  parity enable.
- `DSP_TagCmpValue`  in  24  [21:0] = PA[31:10]; [23:22] are zero.
- `DSP_TagAddr`  in  18  config select; only [3:2] are used.
- `DSP_TagRdStr`  in  1  config read strobe.
- `DSP_TagWrStr`  in  1  config write strobe.
- `DSP_DataRdValue`  out  32  read data.
- `DSP_RPar`  out  4  read parity.
- `DSP_TagRdValue`  out  24  config read data.
- `DSP_Hit`  out  1  access hit the region.
- `DSP_Stall`  out  1  wait state in progress.
- `DSP_Present`  out  1  tied to 1.
- `DSP_ParPresent`  out  1  parity supported.

## Operation
- **Config registers.**
  - `base` holds PA[31:12] (20 bits). `en` is 1 bit.
  - A tag write in cycle N loads `base` from `DSP_TagCmpValue[23:4]` and `en` from `DSP_TagCmpValue[0]`.
  - A tag read in cycle N drives `DSP_TagRdValue` in cycle N+1:
    - `DSP_TagAddr[3:2]`=0 returns {base, 3'b0, en}.
    - `DSP_TagAddr[3:2]`=1 returns {15'b0, ADDR_BITS[4:0], 4'b0}.
    - Any other select returns 0.
  - `DSP_TagRdValue` holds its value between reads.
- **Hit rule.** hit = `en` AND PA[31:ADDR_BITS+2] == base[31:ADDR_BITS+2]. PA comes from `DSP_TagCmpValue` sampled in the response cycle.
- **Access FSM** with states IDLE, WAIT and RESP:
  - In IDLE, a strobe latches address, mask, data and parity, plus a `wr` flag.
  - WAIT_STATES=0: go to RESP. Otherwise go to WAIT with counter = WAIT_STATES.
  - WAIT: `DSP_Stall`=1. The counter decrements each cycle; on reaching 1, go to RESP.
  - RESP: `DSP_Stall`=0 and `DSP_Hit`=hit.
    - Read: `DSP_DataRdValue` and `DSP_RPar` are driven from the array.
    - Write: the masked write is committed at the end of RESP only if hit=1.
    - A new strobe in RESP is accepted, giving back-to-back operation; otherwise go to IDLE.
- **Strobes during WAIT** are ignored; the core holds its request.
- **Simultaneous read and write strobes**: handled as a write. Read outputs hold their previous value.
- **Tag and data strobes in the same cycle**: both are serviced. A tag write in cycle N affects the hit of a data access strobed in cycle N.
- **Read after write**: a read strobed in the RESP cycle of a write to the same word returns the newly merged data (bypass).
- **Miss reads**: `DSP_DataRdValue` still returns array contents; the core qualifies them with `DSP_Hit`.

## Timing
- Read latency is 1+WAIT_STATES cycles from strobe to data. `DSP_Hit` is valid only in RESP and is 0 otherwise.
- Throughput is one access per 1+WAIT_STATES cycles.
- Reset values:
  - `base`=0, `en`=0, FSM=IDLE.
  - `DSP_DataRdValue`=0, `DSP_RPar`=0, `DSP_TagRdValue`=0, `DSP_Hit`=0, `DSP_Stall`=0.
  - `DSP_Present`=1.
- Array contents are not reset.
- Reset asserted mid-access forces IDLE in the next cycle. A pending write is discarded and the array is left untouched.
- Address wrap: index bits above ADDR_BITS are ignored by the array. Region membership is decided by the hit rule alone.

## Configuration
- `M14K_DSPRAM_PARITY_EN` defined:
  - Each word stores 4 parity bits, written per byte under the mask from `DSP_WPar` when `DSP_ParityEn`=1, else written as 0.
  - `DSP_RPar` returns the stored bits and `DSP_ParPresent`=1.
- Undefined:
  - No parity storage.
  - `DSP_RPar`=0 and `DSP_ParPresent`=0 constantly.

## Test plan
- Reset, then tag write with CmpValue={20'h00080,3'b0,1'b1}, then tag read with TagAddr[3:2]=0 -> TagRdValue=24'h000801 the cycle after the read strobe.
- With base=0x00080 and en=1 (WAIT_STATES=0): write 0xDEADBEEF with mask 4'b1111 to PA 0x0008_0010, then write 0x000000AA with mask 4'b0001 to the same PA, then read -> Hit=1 each RESP and RdValue=0xDEADBEAA.
- Access to PA 0x0010_0010 -> Hit=0. A write there leaves the array unchanged (confirmed by a hit read of index 4).
- WAIT_STATES=2, read strobe -> Stall=1 for 2 cycles, then data and Hit in cycle 3. A second strobe raised during the stall is ignored.
- Write to index 5 followed immediately by a read of index 5 -> read returns the new data (bypass).
- greset_n low during the WAIT of a hit write -> Stall=0 next cycle and the array word is unchanged. With parity enabled, write DSP_WPar=4'b1010 with DSP_ParityEn=1 and read back -> RPar=4'b1010.
